// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture unit for the cpu_6s46 core.
// Records {pc, snap_data} of retired instructions into a circular buffer.
// Capture stops on a PC match or forced trigger after a programmable
// post-trigger count, or when the stall watchdog expires. The frozen trace
// is then drained oldest-first.
//
// Handshake: an entry moves when rd_valid and rd_ready are both high at a
// rising clk edge. While rd_valid is high and rd_ready is low, rd_data and
// rd_last hold. rd_valid never drops until the entry flagged rd_last has
// been accepted.
module cpu_trace_buffer #(
    parameter int DEPTH           = 256,
    parameter int PC_WIDTH        = 13,
    parameter int DATA_WIDTH      = 74,
    parameter int WATCHDOG_CYCLES = 131072,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic                         in_interrupt,
    input  logic [PC_WIDTH-1:0]          pc,
    input  logic [DATA_WIDTH-1:0]        snap_data,
    input  logic                         filter_irq,
    input  logic                         arm,
    input  logic [PC_WIDTH-1:0]          trig_pc,
    input  logic [PC_WIDTH-1:0]          trig_mask,
    input  logic                         trig_force,
    input  logic [AW-1:0]                post_count,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [PC_WIDTH+DATA_WIDTH-1:0] rd_data,
    output logic                         rd_last,
    output logic [1:0]                   state,
    output logic [AW:0]                  entry_count,
    output logic                         stall
);

    localparam int EW  = PC_WIDTH + DATA_WIDTH;
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, post_lat, remaining;
    logic [AW:0]      rd_left;
    logic [WDW-1:0]   wd_cnt;
    logic             rd_started;

    logic             cap, pc_hit, wd_last, rd_fire;
    logic             do_write, do_arm, do_trig, wd_expire, rd_start;
    logic [AW-1:0]    start_ptr;

    assign state     = state_q;
    assign cap       = step & ~(filter_irq & in_interrupt);
    assign pc_hit    = (((pc ^ trig_pc) & trig_mask) == '0);
    assign wd_last   = (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));
    assign rd_fire   = rd_valid & rd_ready;
    // With a full buffer the low bits of entry_count are zero, so the
    // oldest entry sits at the write pointer.
    assign start_ptr = wr_ptr - entry_count[AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_d   = state_q;
        do_write  = 1'b0;
        do_arm    = 1'b0;
        do_trig   = 1'b0;
        wd_expire = 1'b0;
        rd_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    do_arm  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                do_write = cap;
                if ((cap & pc_hit) | trig_force) begin
                    do_trig = 1'b1;
                    state_d = (post_lat == '0) ? S_DONE : S_POST;
                end else if (!step && wd_last) begin
                    wd_expire = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_POST: begin
                do_write = cap;
                if (cap && remaining == AW'(1)) begin
                    state_d = S_DONE;
                end else if (!step && wd_last) begin
                    wd_expire = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!rd_started) begin
                    if (entry_count == '0) state_d = S_IDLE;
                    else                   rd_start = 1'b1;
                end else if (rd_fire && rd_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trace RAM write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {pc, snap_data};
    end

    // Capture bookkeeping, watchdog and prefetching readout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            entry_count <= '0;
            stall       <= 1'b0;
            wd_cnt      <= '0;
            post_lat    <= '0;
            remaining   <= '0;
            rd_started  <= 1'b0;
            rd_ptr      <= '0;
            rd_left     <= '0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_data     <= '0;
        end else begin
            if (do_arm) begin
                post_lat    <= post_count;
                stall       <= 1'b0;
                entry_count <= '0;
                wd_cnt      <= '0;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (entry_count != (AW+1)'(DEPTH)) entry_count <= entry_count + 1'b1;
            end
            if (state_q == S_ARMED || state_q == S_POST)
                wd_cnt <= step ? '0 : wd_cnt + 1'b1;
            if (wd_expire) stall <= 1'b1;
            if (do_trig)
                remaining <= post_lat;
            else if (state_q == S_POST && cap)
                remaining <= remaining - 1'b1;

            if (state_q != S_DONE) begin
                rd_started <= 1'b0;
            end else if (rd_start) begin
                // First entry is loaded here; rd_ptr then runs one ahead.
                rd_started <= 1'b1;
                rd_data    <= mem[start_ptr];
                rd_ptr     <= start_ptr + 1'b1;
                rd_left    <= entry_count - 1'b1;
                rd_valid   <= 1'b1;
                rd_last    <= (entry_count == (AW+1)'(1));
            end else if (rd_fire) begin
                if (rd_last) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end else begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + 1'b1;
                    rd_left <= rd_left - 1'b1;
                    rd_last <= (rd_left == (AW+1)'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer with a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PCW   = 13;
    localparam int DW    = 74;
    localparam int WD    = 16;
    localparam int AW    = 3;
    localparam int EW    = PCW + DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            step, in_interrupt, filter_irq, arm, trig_force, rd_ready;
    logic [PCW-1:0]  pc, trig_pc, trig_mask;
    logic [DW-1:0]   snap_data;
    logic [AW-1:0]   post_count;
    logic            rd_valid, rd_last, stall;
    logic [EW-1:0]   rd_data;
    logic [1:0]      state;
    logic [AW:0]     entry_count;

    cpu_trace_buffer #(
        .DEPTH(DEPTH), .PC_WIDTH(PCW), .DATA_WIDTH(DW), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .step(step), .in_interrupt(in_interrupt),
        .pc(pc), .snap_data(snap_data), .filter_irq(filter_irq), .arm(arm),
        .trig_pc(trig_pc), .trig_mask(trig_mask), .trig_force(trig_force),
        .post_count(post_count), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .state(state),
        .entry_count(entry_count), .stall(stall)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: held entries oldest-first, plus capture-phase status.
    logic [EW-1:0] exp_q[$];
    int m_state = 0;
    int m_post  = 0;
    int m_rem   = 0;
    int m_wd    = 0;
    bit m_stall = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by the cycle whose inputs are currently driven.
    task automatic model_update();
        bit capt, moved;
        if (reset) begin
            m_state = 0; m_wd = 0; m_stall = 0;
            exp_q.delete();
            return;
        end
        capt  = step && !(filter_irq && in_interrupt);
        moved = 0;
        case (m_state)
            0: if (arm) begin
                m_post = int'(post_count); m_stall = 0; m_wd = 0;
                exp_q.delete();
                m_state = 1;
            end
            1, 2: begin
                if (capt) begin
                    exp_q.push_back({pc, snap_data});
                    if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
                end
                m_wd = step ? 0 : m_wd + 1;
                if (m_state == 1) begin
                    if ((capt && ((pc ^ trig_pc) & trig_mask) == 0) || trig_force) begin
                        m_rem   = m_post;
                        m_state = (m_post == 0) ? 3 : 2;
                        moved   = 1;
                    end
                end else if (capt) begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 3; moved = 1; end
                end
                if (!moved && m_wd == WD) begin
                    m_stall = 1; m_state = 3;
                end
            end
            default: ;
        endcase
    endtask

    // One clock cycle: model update, then observe DUT at the next negedge.
    task automatic cycle();
        model_update();
        @(negedge clk);
        check("state", 128'(state), 128'(m_state));
        check("entry_count", 128'(entry_count), 128'(exp_q.size()));
        check("stall", 128'(stall), 128'(m_stall));
        if (m_state != 3) check("rd_valid_idle", 128'(rd_valid), 128'(0));
    endtask

    // Driver tasks.
    task automatic do_arm(input logic [PCW-1:0] tp, input logic [PCW-1:0] tm, input int post);
        trig_pc = tp; trig_mask = tm; post_count = AW'(post);
        arm = 1'b1; cycle(); arm = 1'b0;
    endtask

    task automatic do_step(input logic [PCW-1:0] p, input logic irq);
        pc = p; in_interrupt = irq;
        snap_data = DW'({$urandom(), $urandom(), $urandom()});
        step = 1'b1; cycle(); step = 1'b0; in_interrupt = 1'b0;
    endtask

    task automatic do_force();
        trig_force = 1'b1; cycle(); trig_force = 1'b0;
    endtask

    // Drain the frozen trace; mode 0 ready always, 1 toggling, 2 random.
    task automatic drain(input int mode);
        logic [EW-1:0] q[$];
        logic [EW-1:0] held_d;
        logic held_l;
        bit prev_hold, rdy;
        int waitc, budget;
        q = exp_q;
        if (q.size() == 0) begin
            check("empty_valid", 128'(rd_valid), 128'(0));
            rd_ready = 1'b1;
            @(negedge clk);
            check("empty_state", 128'(state), 128'(0));
            check("empty_valid2", 128'(rd_valid), 128'(0));
            rd_ready = 1'b0; m_state = 0;
            return;
        end
        waitc = 0;
        while (!rd_valid && waitc < 3) begin @(negedge clk); waitc++; end
        check("valid_latency", 128'(waitc <= 2), 128'(1));
        prev_hold = 0; budget = 0; held_d = '0; held_l = 1'b0;
        while (q.size() > 0 && budget < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
            if (prev_hold) begin
                check("hold_data", 128'(rd_data), 128'(held_d));
                check("hold_last", 128'(rd_last), 128'(held_l));
            end
            if (mode == 0) check("no_bubble", 128'(rd_valid), 128'(1));
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                check("rd_data", 128'(rd_data), 128'(q[0]));
                void'(q.pop_front());
                check("rd_last", 128'(rd_last), 128'(q.size() == 0));
                prev_hold = 0;
            end else begin
                prev_hold = rd_valid; held_d = rd_data; held_l = rd_last;
            end
            @(negedge clk);
            budget++;
        end
        rd_ready = 1'b0;
        check("drain_left", 128'(q.size()), 128'(0));
        check("after_valid", 128'(rd_valid), 128'(0));
        check("after_state", 128'(state), 128'(0));
        m_state = 0;
    endtask

    initial begin
        reset = 1'b1; step = 0; in_interrupt = 0; filter_irq = 0; arm = 0;
        trig_force = 0; rd_ready = 0; pc = '0; trig_pc = '0; trig_mask = '0;
        snap_data = '0; post_count = '0;
        repeat (2) @(negedge clk);
        cycle();
        check("rst_rd_data", 128'(rd_data), 128'(0));
        check("rst_rd_last", 128'(rd_last), 128'(0));
        reset = 1'b0;
        cycle();

        // Single entry, match-any, no post-trigger; then idle steps are dropped.
        do_arm(13'h0, 13'h0, 0);
        do_step(13'h100, 1'b0);
        check("single_pc", 128'(exp_q[0][EW-1:DW]), 128'(13'h100));
        drain(0);
        for (int i = 0; i < 3; i++) do_step(13'(i), 1'b0);

        // No trigger, buffer wraps, forced stop.
        do_arm(13'h0FFF, 13'h1FFF, 0);
        for (int i = 0; i < 20; i++) do_step(13'(i), 1'b0);
        do_force();
        drain(0);

        // PC trigger with post count 3; trailing steps dropped in DONE.
        do_arm(13'h040, 13'h1FFF, 3);
        for (int i = 'h3C; i <= 'h46; i++) do_step(13'(i), 1'b0);
        drain(0);

        // Interrupt filtering on and off.
        for (int f = 1; f >= 0; f--) begin
            filter_irq = 1'(f);
            do_arm(13'h1FFF, 13'h1FFF, 0);
            for (int i = 0; i < 8; i++) do_step(13'(i + 'h200), 1'(i % 2));
            do_force();
            drain(0);
        end
        filter_irq = 1'b0;

        // Watchdog after 3 steps, then re-arm clears stall.
        do_arm(13'h1FFF, 13'h1FFF, 0);
        for (int i = 0; i < 3; i++) do_step(13'(i + 'h300), 1'b0);
        for (int g = 0; g < 40 && m_state != 3; g++) cycle();
        check("wd_stall", 128'(stall), 128'(1));
        drain(0);
        do_arm(13'h1FFF, 13'h1FFF, 0);
        do_step(13'h310, 1'b0);
        do_force();
        drain(1);

        // Watchdog with nothing captured.
        do_arm(13'h1FFF, 13'h1FFF, 0);
        for (int g = 0; g < 40 && m_state != 3; g++) cycle();
        drain(0);

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            filter_irq = 1'($urandom_range(0, 1));
            do_arm(13'($urandom()), 13'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            for (int i = 0; i < 30 && m_state != 3; i++) begin
                if ($urandom_range(0, 9) == 0) do_force();
                else do_step(13'($urandom()), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) cycle();
            end
            for (int g = 0; g < 100 && m_state != 3; g++) begin
                if (m_state == 1) do_force();
                else do_step(13'($urandom()), 1'b0);
            end
            drain((r % 3 == 0) ? 1 : 2);
        end
        filter_irq = 1'b0;

        // Reset in the middle of readout.
        do_arm(13'h1FFF, 13'h1FFF, 0);
        for (int i = 0; i < 5; i++) do_step(13'(i + 'h400), 1'b0);
        do_force();
        for (int g = 0; g < 3 && !rd_valid; g++) @(negedge clk);
        check("mid_valid", 128'(rd_valid), 128'(1));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        reset = 1'b1;
        cycle();
        check("mid_rst_valid", 128'(rd_valid), 128'(0));
        check("mid_rst_last", 128'(rd_last), 128'(0));
        reset = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable, parametrised instruction-trace capture unit for the cpu_6s46 core. It snapshots architectural state on every retired instruction into a circular buffer, stops on a PC-match or forced trigger after a programmable post-trigger count, and includes a stall watchdog. The frozen trace drains oldest-first over a valid/ready stream to a debug host or simulation logger.

Parameters:
DEPTH, 256, trace entries; power of two, at least 4
PC_WIDTH, 13, program counter width
DATA_WIDTH, 74, snapshot payload width (opcode, SP, NP, X, Y, A, B, flags), opaque to the block
WATCHDOG_CYCLES, 131072, clk cycles without a step before a stall is declared; at least 2
AW, $clog2(DEPTH), derived address width; not overridable

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
step  in  1  one-cycle pulse at the CPU's last microcode cycle of an instruction
in_interrupt  in  1  CPU is executing an interrupt sequence
pc  in  PC_WIDTH  PC of the retiring instruction, valid with step
snap_data  in  DATA_WIDTH  state snapshot, valid with step
filter_irq  in  1  when set, steps with in_interrupt=1 are not captured
arm  in  1  pulse: start capture; honoured only in IDLE
trig_pc  in  PC_WIDTH  trigger PC compare value
trig_mask  in  PC_WIDTH  compare mask; 1 = bit compared, all-zero matches any PC
trig_force  in  1  pulse: immediate trigger
post_count  in  AW  entries captured after the trigger entry; sampled on arm
rd_valid  out  1  output entry available
rd_ready  in  1  consumer accepts the entry
rd_data  out  PC_WIDTH+DATA_WIDTH  {pc, snap_data} of the entry
rd_last  out  1  marks the newest entry
state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
entry_count  out  AW+1  valid entries held, saturating at DEPTH
stall  out  1  sticky watchdog flag

Behaviour:
- Reset, from any state and including mid-readout: state=IDLE, rd_valid=0, rd_last=0, rd_data=0, entry_count=0, stall=0, write pointer=0, watchdog count=0. Buffer RAM contents are not cleared.
- Capture qualifier: cap = step & ~(filter_irq & in_interrupt). Capture writes {pc, snap_data} at the write pointer. The pointer wraps modulo DEPTH. entry_count increments and saturates at DEPTH; the oldest entry is overwritten when full.
- IDLE: no capture. On arm: latch post_count, clear stall, clear entry_count and the watchdog count, then go to ARMED. arm is ignored in every other state.
- ARMED: capture on cap. A trigger fires when cap & ((pc ^ trig_pc) & trig_mask)==0. The triggering entry is written in the same cycle.
  - If the latched post_count is 0, go to DONE. Otherwise go to POST with remaining = post_count.
- trig_force in ARMED with no cap that cycle: go to POST, or to DONE if post_count is 0. No entry is written.
- trig_force together with cap: treated as a trigger on that entry.
- POST: each cap writes an entry and decrements remaining. The write that brings remaining to 0 moves the block to DONE in the next cycle. trig_force and PC matches are ignored.
- Watchdog, ARMED and POST only:
  - The count resets on every step, whether or not it is filtered, and increments otherwise.
  - On reaching WATCHDOG_CYCLES: set stall=1 and go to DONE. Entries already captured are kept.
- DONE:
  - The read pointer starts at (wr_ptr - entry_count) mod DEPTH.
  - rd_valid rises no later than 2 cycles after entering DONE. rd_data is registered; the RAM read is prefetched.
  - rd_data and rd_last hold stable while rd_valid & ~rd_ready.
  - Each valid&ready transfer advances to the next entry with no bubble cycles while rd_ready stays high.
  - rd_last=1 only on the newest entry. After its transfer: rd_valid=0, state=IDLE. entry_count and stall hold until the next arm.
  - entry_count=0 in DONE (stall before any capture): rd_valid stays 0 and the block returns to IDLE in the next cycle.
- No capture in DONE or IDLE. Steps arriving then are dropped.

Test Plan:
- Arm with mask=0, post_count=0, one step pc=0x100 -> one entry written, DONE, entry_count=1, single transfer with rd_last=1 and rd_data pc field 0x100, then IDLE.
- DEPTH=8, trig_pc=0x0FFF, mask=all-ones, 20 steps pc=0..19 -> no trigger, entry_count saturates at 8; trig_force -> DONE; readout gives pc 12..19 in order, rd_last on 19.
- DEPTH=8, post_count=3, trigger at pc=0x040 in stream 0x03C..0x046 -> captured pcs 0x03C..0x043; trigger entry is 5th of 8; DONE one cycle after pc=0x043.
- filter_irq=1, steps alternating in_interrupt 0/1 -> only non-interrupt pcs captured; with filter_irq=0 all captured.
- WATCHDOG_CYCLES=16, ARMED, 3 steps, then idle 16 cycles -> stall=1, DONE, 3 entries drained; next arm clears stall.
- rd_ready toggled 1/0 every cycle during readout -> rd_data is stable when not accepted, no entries lost or duplicated. Reset asserted mid-readout -> rd_valid=0, state=IDLE next cycle.
